// File: rtl/inst_rom_loader.sv
// Boot-loaded instruction memory: combinational fetch port for the core, byte-wide load FSM.
// Optional running checksum of written words is built when INST_ROM_CHECKSUM_EN is defined.
module inst_rom_loader #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] addr_i,
    output logic [31:0] inst_o,
    input  logic        load_start_i,
    input  logic        load_valid_i,
    input  logic [7:0]  load_byte_i,
    output logic        load_ready_o,
    output logic        boot_done_o,
    output logic        load_err_o,
    output logic [31:0] checksum_o
);

    localparam int          DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [16:0] DEPTH_LIMIT = 17'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        DONE,
        ERR
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [DEPTH_LOG2:0]   ptr_q, ptr_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           word_q, word_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [31:0]           wr_data;

    logic [31:0]           mem [0:DEPTH-1];

    assign accept = load_valid_i && ready_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ptr_d      = ptr_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        wr_en      = 1'b0;
        wr_addr    = ptr_q[DEPTH_LOG2-1:0];
        wr_data    = {word_q, load_byte_i};

        // A start pulse wins over any byte presented in the same cycle.
        if (load_start_i) begin
            state_d    = LEN_HI;
            count_d    = '0;
            ptr_d      = '0;
            byte_cnt_d = '0;
            word_d     = '0;
        end else begin
            case (state_q)
                LEN_HI: begin
                    if (accept) begin
                        count_d = {load_byte_i, count_q[7:0]};
                        state_d = LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        count_d = {count_q[15:8], load_byte_i};
                        if (count_d == 16'd0) begin
                            state_d = DONE;
                        end else if (17'(count_d) > DEPTH_LIMIT) begin
                            state_d = ERR;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        if (byte_cnt_q == 2'd3) begin
                            wr_en      = 1'b1;
                            ptr_d      = ptr_q + 1'b1;
                            byte_cnt_d = '0;
                            word_d     = '0;
                            if (32'(ptr_d) == 32'(count_q)) begin
                                state_d = DONE;
                            end
                        end else begin
                            word_d     = {word_q[15:0], load_byte_i};
                            byte_cnt_d = byte_cnt_q + 2'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        // Status outputs are registered decodes of the upcoming state.
        ready_d = (state_d == LEN_HI) || (state_d == LEN_LO) || (state_d == DATA);
        done_d  = (state_d == DONE);
        err_d   = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            ptr_q      <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ptr_q      <= ptr_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // The array keeps its contents across reset so a partial reload leaves earlier words intact.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef INST_ROM_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (load_start_i) begin
            csum_d = '0;
        end else if (wr_en) begin
            csum_d = csum_q + wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum_o = csum_q;
`else
    assign checksum_o = '0;
`endif

    // Byte offset and address bits above the array are don't-care, so fetches wrap.
    logic [DEPTH_LOG2-1:0] fetch_idx;
    logic                  unused_addr_bits;

    assign fetch_idx        = addr_i[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};

    assign inst_o       = (ce_i && done_q) ? mem[fetch_idx] : 32'd0;
    assign load_ready_o = ready_q;
    assign boot_done_o  = done_q;
    assign load_err_o   = err_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomized bench for inst_rom_loader: a byte-stream session model predicts every output each cycle.
module tb_inst_rom_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] inst_o;
    logic        load_start_i = 1'b0;
    logic        load_valid_i = 1'b0;
    logic [7:0]  load_byte_i = '0;
    logic        load_ready_o;
    logic        boot_done_o;
    logic        load_err_o;
    logic [31:0] checksum_o;

    always #5 clk = ~clk;

    inst_rom_loader #(.DEPTH_LOG2(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .ce_i         (ce_i),
        .addr_i       (addr_i),
        .inst_o       (inst_o),
        .load_start_i (load_start_i),
        .load_valid_i (load_valid_i),
        .load_byte_i  (load_byte_i),
        .load_ready_o (load_ready_o),
        .boot_done_o  (boot_done_o),
        .load_err_o   (load_err_o),
        .checksum_o   (checksum_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_fetch = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Session model: everything follows from the ordered list of handshaked bytes.
    logic [31:0] mem_m [0:1023];
    bit          known [0:1023];
    bit          m_active = 1'b0;
    bit          m_done   = 1'b0;
    bit          m_err    = 1'b0;
    int          m_n      = 0;
    int          m_cnt    = 0;
    logic [31:0] m_part   = '0;
    logic [31:0] m_sum    = '0;

    function automatic bit exp_ready();
        return m_active && !m_done && !m_err;
    endfunction

    always @(posedge clk or negedge rst) begin
        int k;
        if (!rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_err    = 1'b0;
            m_n      = 0;
            m_cnt    = 0;
            m_sum    = '0;
            m_part   = '0;
        end else if (load_start_i) begin
            m_active = 1'b1;
            m_done   = 1'b0;
            m_err    = 1'b0;
            m_n      = 0;
            m_cnt    = 0;
            m_sum    = '0;
            m_part   = '0;
        end else if (load_valid_i && exp_ready()) begin
            m_n++;
            if (m_n == 1) begin
                m_cnt = int'(load_byte_i) * 256;
            end else if (m_n == 2) begin
                m_cnt = m_cnt + int'(load_byte_i);
                if (m_cnt == 0) m_done = 1'b1;
                else if (m_cnt > 1024) m_err = 1'b1;
            end else begin
                k = m_n - 3;
                m_part = {m_part[23:0], load_byte_i};
                if (k % 4 == 3) begin
                    mem_m[k/4] = m_part;
                    known[k/4] = 1'b1;
                    m_sum      = m_sum + m_part;
                    if (k/4 + 1 == m_cnt) m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        int idx;
        check32("load_ready_o", 32'(load_ready_o), 32'(exp_ready()));
        check32("boot_done_o", 32'(boot_done_o), 32'(m_done));
        check32("load_err_o", 32'(load_err_o), 32'(m_err));
`ifdef INST_ROM_CHECKSUM_EN
        check32("checksum_o", checksum_o, m_sum);
`else
        check32("checksum_o", checksum_o, 32'd0);
`endif
        idx = int'(addr_i[11:2]);
        if (!(ce_i && m_done)) check32("inst_o_gated", inst_o, 32'd0);
        else if (known[idx]) check32("inst_o", inst_o, mem_m[idx]);
    end

    task automatic tick();
        int idx;
        @(posedge clk);
        #2;
        if (rand_fetch) begin
            ce_i   = ($urandom % 4) != 0;
            idx    = ($urandom % 2 == 0) ? $urandom_range(0, 63) : $urandom_range(0, 1023);
            addr_i = ($urandom & 32'hFFFF_F003) | (32'(idx) << 2);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int prob);
        int budget;
        bit sent;
        budget = 0;
        sent   = 1'b0;
        while (!sent) begin
            load_valid_i = ($urandom_range(0, 99) < prob);
            load_byte_i  = load_valid_i ? b : 8'($urandom);
            sent         = load_valid_i && exp_ready();
            tick();
            budget++;
            if (!sent && budget > 300) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_byte_timeout: got no handshake expected byte %h accepted", b);
                sent = 1'b1;
            end
        end
        load_valid_i = 1'b0;
    endtask

    task automatic start_session(input bit with_junk);
        load_start_i = 1'b1;
        load_valid_i = with_junk;
        load_byte_i  = 8'h5A;
        tick();
        load_start_i = 1'b0;
        load_valid_i = 1'b0;
    endtask

    task automatic send_count(input logic [15:0] cnt, input int prob);
        send_byte(cnt[15:8], prob);
        send_byte(cnt[7:0], prob);
    endtask

    task automatic send_word(input logic [31:0] w, input int prob);
        send_byte(w[31:24], prob);
        send_byte(w[23:16], prob);
        send_byte(w[15:8], prob);
        send_byte(w[7:0], prob);
    endtask

    task automatic load_image(input logic [31:0] words[$], input int prob, input bit junk);
        start_session(junk);
        send_count(16'(words.size()), prob);
        foreach (words[i]) send_word(words[i], prob);
    endtask

    task automatic fetch_check(input string name, input logic c, input logic [31:0] a,
                               input logic [31:0] exp);
        ce_i   = c;
        addr_i = a;
        #1;
        check32(name, inst_o, exp);
    endtask

    initial begin
        logic [31:0] img[$];
        logic [31:0] big[$];
        int          cnt;

        repeat (3) tick();
        ce_i = 1'b1;
        #1;
        check32("reset_ready", 32'(load_ready_o), 32'd0);
        check32("reset_done", 32'(boot_done_o), 32'd0);
        check32("reset_err", 32'(load_err_o), 32'd0);
        check32("reset_checksum", checksum_o, 32'd0);
        check32("reset_inst", inst_o, 32'd0);
        rst = 1'b1;
        tick();

        img = '{32'h3401_0001, 32'h3C02_0002};
        load_image(img, 100, 1'b0);
        #1;
        check32("img_done", 32'(boot_done_o), 32'd1);
        check32("img_ready", 32'(load_ready_o), 32'd0);
        fetch_check("fetch_0", 1'b1, 32'h0000_0000, 32'h3401_0001);
        fetch_check("fetch_4", 1'b1, 32'h0000_0004, 32'h3C02_0002);
        fetch_check("fetch_wrap", 1'b1, 32'h0000_1003, 32'h3401_0001);
        fetch_check("fetch_ce0", 1'b0, 32'h0000_0000, 32'd0);
`ifdef INST_ROM_CHECKSUM_EN
        check32("img_checksum", checksum_o, 32'h7003_0003);
`endif

        ce_i = 1'b1;
        start_session(1'b1);
        fetch_check("fetch_before_done", 1'b1, 32'h0000_0000, 32'd0);
        check32("restart_ready", 32'(load_ready_o), 32'd1);
        send_count(16'd2, 100);
        send_word(32'h3401_0001, 100);
        send_word(32'h3C02_0002, 100);
        fetch_check("reload_fetch_4", 1'b1, 32'h0000_0004, 32'h3C02_0002);

        start_session(1'b0);
        send_count(16'h0401, 100);
        #1;
        check32("err_flag", 32'(load_err_o), 32'd1);
        check32("err_ready", 32'(load_ready_o), 32'd0);
        check32("err_done", 32'(boot_done_o), 32'd0);
        start_session(1'b0);
        #1;
        check32("err_cleared", 32'(load_err_o), 32'd0);
        check32("err_restart_ready", 32'(load_ready_o), 32'd1);
        send_count(16'h0000, 100);
        #1;
        check32("zero_done", 32'(boot_done_o), 32'd1);
        check32("zero_ready", 32'(load_ready_o), 32'd0);

        rand_fetch = 1'b1;
        repeat (4) begin
            cnt = $urandom_range(1, 48);
            img.delete();
            repeat (cnt) img.push_back($urandom);
            load_image(img, 50, $urandom % 2);
            repeat (100) tick();
        end
        rand_fetch = 1'b0;

        start_session(1'b0);
        send_count(16'd3, 100);
        send_byte(8'h11, 100);
        send_byte(8'h22, 100);
        rst = 1'b0;
        #1;
        check32("midreset_ready", 32'(load_ready_o), 32'd0);
        check32("midreset_done", 32'(boot_done_o), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        img.delete();
        img.push_back(32'hDEAD_BEEF);
        load_image(img, 100, 1'b1);
        fetch_check("deadbeef_fetch", 1'b1, 32'h0000_0000, 32'hDEAD_BEEF);
        check32("deadbeef_done", 32'(boot_done_o), 32'd1);
`ifdef INST_ROM_CHECKSUM_EN
        check32("deadbeef_checksum", checksum_o, 32'hDEAD_BEEF);
`endif

        big.delete();
        repeat (1024) big.push_back($urandom);
        load_image(big, 100, 1'b0);
        fetch_check("full_last", 1'b1, 32'h0000_0FFC, big[1023]);
        fetch_check("full_first_wrap", 1'b1, 32'h0001_0000, big[0]);

        rand_fetch = 1'b1;
        repeat (200) tick();
        rand_fetch = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
